// File: rtl/control_capa_fisica.sv
// rtl/control_capa_fisica.sv - CMD-line physical-layer controller for an SD host
//
// Sequences one command/response exchange on the SD CMD pad. It loads and
// enables the parallel-to-serial wrapper to send a command. It then turns the
// pad around and enables the serial-to-parallel wrapper to collect the
// response, or declares a timeout. Finally it hands the result to the upper
// layer and holds it until the upper layer acknowledges it.
//
// Ports:
//   sd_clock               sole clock, rising edge
//   reset                  asynchronous active-low reset
//   strobe_in              command request from the upper layer (sampled in IDLE only)
//   ack_in                 upper layer consumed the response (sampled in SEND_RESPONSE only)
//   idle_in                abort / hold idle, wins over everything except reset
//   no_response            current command expects no response
//   pad_response[135:0]    deserialized response from the serial-to-parallel wrapper
//   reception_complete     serial-to-parallel wrapper finished a response
//   transmission_complete  parallel-to-serial wrapper finished the command
//   ack_out                one-cycle command-accepted pulse
//   strobe_out             response or timeout available
//   response[135:0]        latched response (zero on timeout or no-response)
//   command_timeout        no response within TIMEOUT_CYCLES
//   load_send              one-cycle load pulse to the parallel-to-serial wrapper
//   enable_pts_wrapper     parallel-to-serial wrapper enable
//   enable_stp_wrapper     serial-to-parallel wrapper enable
//   pad_state              CMD pad direction, 1 = drive, 0 = receive
//   pad_enable             CMD pad buffer enable
//   reset_wrapper          active-high reset to both wrappers

module control_capa_fisica #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic         ack_in,
    input  logic         idle_in,
    input  logic         no_response,
    input  logic [135:0] pad_response,
    input  logic         reception_complete,
    input  logic         transmission_complete,
    output logic         ack_out,
    output logic         strobe_out,
    output logic [135:0] response,
    output logic         command_timeout,
    output logic         load_send,
    output logic         enable_pts_wrapper,
    output logic         enable_stp_wrapper,
    output logic         pad_state,
    output logic         pad_enable,
    output logic         reset_wrapper
);

    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] SEND_COMMAND  = 2'd1;
    localparam logic [1:0] WAIT_RESPONSE = 2'd2;
    localparam logic [1:0] SEND_RESPONSE = 2'd3;

    // One spare bit so TIMEOUT_CYCLES-1 always fits, even for powers of two.
    localparam int              CW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] counter;

    // Every output is a register written with the value it must hold in the
    // state being entered, so outputs line up with the state they describe.
    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            counter            <= '0;
            response           <= '0;
            ack_out            <= 1'b0;
            load_send          <= 1'b0;
            strobe_out         <= 1'b0;
            command_timeout    <= 1'b0;
            enable_pts_wrapper <= 1'b0;
            enable_stp_wrapper <= 1'b0;
            pad_state          <= 1'b0;
            pad_enable         <= 1'b0;
            reset_wrapper      <= 1'b1;
        end else begin
            // Accept pulses last exactly one cycle.
            ack_out   <= 1'b0;
            load_send <= 1'b0;

            if (idle_in) begin
                // Abort: response is deliberately left untouched.
                state              <= IDLE;
                counter            <= '0;
                strobe_out         <= 1'b0;
                command_timeout    <= 1'b0;
                enable_pts_wrapper <= 1'b0;
                enable_stp_wrapper <= 1'b0;
                pad_state          <= 1'b0;
                pad_enable         <= 1'b0;
                reset_wrapper      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (strobe_in) begin
                            state              <= SEND_COMMAND;
                            ack_out            <= 1'b1;
                            load_send          <= 1'b1;
                            enable_pts_wrapper <= 1'b1;
                            pad_enable         <= 1'b1;
                            pad_state          <= 1'b1;
                            reset_wrapper      <= 1'b0;
                        end
                    end
                    SEND_COMMAND: begin
                        if (transmission_complete) begin
                            enable_pts_wrapper <= 1'b0;
                            pad_state          <= 1'b0;
                            counter            <= '0;
                            if (no_response) begin
                                state           <= SEND_RESPONSE;
                                response        <= '0;
                                command_timeout <= 1'b0;
                                strobe_out      <= 1'b1;
                                pad_enable      <= 1'b0;
                            end else begin
                                state              <= WAIT_RESPONSE;
                                enable_stp_wrapper <= 1'b1;
                            end
                        end
                    end
                    WAIT_RESPONSE: begin
                        // Reception is tested first so it wins a tie with the timeout.
                        if (reception_complete || counter == WAIT_LAST) begin
                            state              <= SEND_RESPONSE;
                            counter            <= '0;
                            strobe_out         <= 1'b1;
                            enable_stp_wrapper <= 1'b0;
                            pad_enable         <= 1'b0;
                            response           <= reception_complete ? pad_response : '0;
                            command_timeout    <= !reception_complete;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: begin
                        if (ack_in) begin
                            state           <= IDLE;
                            strobe_out      <= 1'b0;
                            command_timeout <= 1'b0;
                            reset_wrapper   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_capa_fisica.sv
// tb/tb_control_capa_fisica.sv - self-checking bench for control_capa_fisica
module tb_control_capa_fisica;

    localparam int TO = 64;

    logic         sd_clock = 1'b0;
    logic         reset = 1'b0;
    logic         strobe_in = 1'b0, ack_in = 1'b0, idle_in = 1'b0, no_response = 1'b0;
    logic [135:0] pad_response = '0;
    logic         reception_complete = 1'b0, transmission_complete = 1'b0;
    logic         ack_out, strobe_out, command_timeout, load_send;
    logic         enable_pts_wrapper, enable_stp_wrapper, pad_state, pad_enable, reset_wrapper;
    logic [135:0] response;

    int errors = 0;
    int checks = 0;

    control_capa_fisica #(.TIMEOUT_CYCLES(TO)) dut (
        .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
        .idle_in(idle_in), .no_response(no_response), .pad_response(pad_response),
        .reception_complete(reception_complete), .transmission_complete(transmission_complete),
        .ack_out(ack_out), .strobe_out(strobe_out), .response(response),
        .command_timeout(command_timeout), .load_send(load_send),
        .enable_pts_wrapper(enable_pts_wrapper), .enable_stp_wrapper(enable_stp_wrapper),
        .pad_state(pad_state), .pad_enable(pad_enable), .reset_wrapper(reset_wrapper)
    );

    always #5 sd_clock = ~sd_clock;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: which phase of the exchange we are in, when the
    // wait began, and the result to be delivered.
    typedef enum {P_IDLE, P_SEND, P_WAIT, P_DELIVER} phase_t;
    phase_t       m_phase = P_IDLE;
    int           m_edges = 0;
    int           m_wait_start = 0;
    bit           m_first = 0;
    bit           m_to = 0;
    logic [135:0] m_resp = '0;

    always @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            m_phase = P_IDLE; m_resp = '0; m_to = 0; m_first = 0;
        end else begin
            m_edges++;
            m_first = 0;
            if (idle_in) begin
                m_phase = P_IDLE; m_to = 0;
            end else if (m_phase == P_IDLE && strobe_in) begin
                m_phase = P_SEND; m_first = 1;
            end else if (m_phase == P_SEND && transmission_complete) begin
                if (no_response) begin
                    m_phase = P_DELIVER; m_resp = '0; m_to = 0;
                end else begin
                    m_phase = P_WAIT; m_wait_start = m_edges;
                end
            end else if (m_phase == P_WAIT) begin
                // The wait may last TO full cycles; the TO-th edge after entry decides.
                if (reception_complete) begin
                    m_phase = P_DELIVER; m_resp = pad_response; m_to = 0;
                end else if (m_edges - m_wait_start == TO) begin
                    m_phase = P_DELIVER; m_resp = '0; m_to = 1;
                end
            end else if (m_phase == P_DELIVER && ack_in) begin
                m_phase = P_IDLE; m_to = 0;
            end
        end
    end

    always @(negedge sd_clock) begin
        chk("ack_out",            ack_out,            m_first);
        chk("load_send",          load_send,          m_first);
        chk("enable_pts_wrapper", enable_pts_wrapper, m_phase == P_SEND);
        chk("enable_stp_wrapper", enable_stp_wrapper, m_phase == P_WAIT);
        chk("pad_enable",         pad_enable,         m_phase == P_SEND || m_phase == P_WAIT);
        chk("pad_state",          pad_state,          m_phase == P_SEND);
        chk("reset_wrapper",      reset_wrapper,      m_phase == P_IDLE);
        chk("strobe_out",         strobe_out,         m_phase == P_DELIVER);
        chk("command_timeout",    command_timeout,    m_phase == P_DELIVER && m_to);
        chk("response",           response,           m_resp);
    end

    task automatic step();
        @(negedge sd_clock); #1;
    endtask

    task automatic start_cmd();
        strobe_in = 1; step(); strobe_in = 0;
    endtask

    task automatic send_done(input bit nr);
        no_response = nr; transmission_complete = 1; step();
        transmission_complete = 0; no_response = 0;
    endtask

    task automatic wait_strobe(input int limit);
        int n = 0;
        while (!strobe_out && n < limit) begin step(); n++; end
        chk("strobe_out_within_bound", strobe_out, 1'b1);
    endtask

    task automatic deliver_ack();
        ack_in = 1; step(); ack_in = 0;
        chk("idle_after_ack_strobe", strobe_out, 1'b0);
        chk("idle_after_ack_rw", reset_wrapper, 1'b1);
    endtask

    logic [135:0] pat_a, pat_b;
    int           cnt;
    bit           seen;

    initial begin
        pat_a = {{16{8'hA5}}, 8'h5A};
        pat_b = {8'h3F, {120{1'b0}}, 8'hC1};

        // Reset held low for three cycles.
        repeat (3) step();
        chk("rst_response", response, '0);
        chk("rst_reset_wrapper", reset_wrapper, 1'b1);
        chk("rst_strobe_out", strobe_out, 1'b0);
        reset = 1; step();

        // Command accepted: one-cycle ack/load, pad driven.
        start_cmd();
        chk("accept_ack_out", ack_out, 1'b1);
        chk("accept_load_send", load_send, 1'b1);
        chk("accept_pad_state", pad_state, 1'b1);
        chk("accept_pad_enable", pad_enable, 1'b1);
        chk("accept_pts", enable_pts_wrapper, 1'b1);
        strobe_in = 1; step(); strobe_in = 0;   // ignored outside IDLE
        chk("ack_one_cycle", ack_out, 1'b0);
        chk("load_one_cycle", load_send, 1'b0);

        // Normal response after 10 cycles; stray ack_in while waiting is ignored.
        send_done(0);
        ack_in = 1; step(); ack_in = 0;
        repeat (9) step();
        chk("still_waiting", enable_stp_wrapper, 1'b1);
        pad_response = pat_a; reception_complete = 1; step(); reception_complete = 0;
        chk("rx_response", response, pat_a);
        chk("rx_model_pin", m_resp, pat_a);
        chk("rx_strobe", strobe_out, 1'b1);
        chk("rx_no_timeout", command_timeout, 1'b0);
        repeat (3) step();
        chk("rx_strobe_held", strobe_out, 1'b1);
        deliver_ack();

        // Timeout: count the cycles the receiver stays enabled.
        start_cmd(); send_done(0);
        cnt = 0;
        while (enable_stp_wrapper && cnt < 200) begin step(); cnt++; end
        chk("timeout_wait_cycles", 32'(cnt), 32'd64);
        chk("timeout_flag", command_timeout, 1'b1);
        chk("timeout_strobe", strobe_out, 1'b1);
        chk("timeout_response", response, '0);
        deliver_ack();
        chk("timeout_cleared", command_timeout, 1'b0);

        // No-response command: straight to delivery, receiver never enabled.
        pad_response = pat_b;
        start_cmd();
        no_response = 1; transmission_complete = 1;
        seen = 0;
        step(); transmission_complete = 0; no_response = 0;
        seen |= enable_stp_wrapper;
        chk("noresp_strobe", strobe_out, 1'b1);
        chk("noresp_timeout", command_timeout, 1'b0);
        repeat (2) begin step(); seen |= enable_stp_wrapper; end
        chk("noresp_stp_never", seen, 1'b0);
        deliver_ack();

        // Reception on the same edge as the timeout: reception wins.
        start_cmd(); send_done(0);
        cnt = 0;
        while (!enable_stp_wrapper && cnt < 10) begin step(); cnt++; end
        repeat (TO - 1) step();
        pad_response = pat_b; reception_complete = 1; step(); reception_complete = 0;
        chk("tie_response", response, pat_b);
        chk("tie_timeout", command_timeout, 1'b0);
        chk("tie_strobe", strobe_out, 1'b1);
        deliver_ack();

        // idle_in during the wait: back to IDLE, response preserved.
        start_cmd(); send_done(0);
        repeat (5) step();
        idle_in = 1; step(); idle_in = 0;
        chk("abort_reset_wrapper", reset_wrapper, 1'b1);
        chk("abort_stp", enable_stp_wrapper, 1'b0);
        chk("abort_response_kept", response, pat_b);
        repeat (TO + 5) step();
        chk("abort_no_strobe", strobe_out, 1'b0);

        // Asynchronous reset in the middle of a wait: no strobe, response cleared.
        start_cmd(); send_done(0);
        repeat (3) step();
        #2 reset = 0; #1;
        chk("async_rst_response", response, '0);
        chk("async_rst_stp", enable_stp_wrapper, 1'b0);
        chk("async_rst_rw", reset_wrapper, 1'b1);
        seen = 0;
        repeat (2) begin step(); seen |= strobe_out; end
        reset = 1;
        repeat (3) begin step(); seen |= strobe_out; end
        chk("async_rst_no_strobe", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
